// File: rtl/snake_hud_renderer_pkg.sv
// Shared definitions for the Snake HUD renderer: pixel class codes, flash FSM
// state encodings and the default play-field / text geometry.
package snake_hud_renderer_pkg;

  typedef enum logic [1:0] {
    CLASS_NONE   = 2'd0,
    CLASS_BORDER = 2'd1,
    CLASS_TEXT   = 2'd2
  } pixel_class_e;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FLASH  = 1'b1
  } flash_state_e;

  localparam int DEF_PIXEL_DISPLAY_BIT = 9;
  localparam int DEF_BORDER_X0         = 53;
  localparam int DEF_BORDER_Y0         = 38;
  localparam int DEF_BORDER_W          = 628;
  localparam int DEF_BORDER_H          = 413;
  localparam int DEF_BORDER_T          = 5;
  localparam int DEF_TEXT_Y0           = 460;
  localparam int DEF_TEXT_H            = 16;
  localparam int DEF_ROM_X_W           = 8;
  localparam int DEF_ROM_LATENCY       = 1;
  localparam int DEF_FLASH_BIT         = 4;

endpackage

// File: rtl/hud_delay_line.sv
// Fixed-depth register chain used to line the HUD flags up with glyph ROM data.
// DEPTH = 0 degenerates to a plain wire.
module hud_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 1
) (
  input  logic             clock_25,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_s;
      assign unused_s = clock_25 ^ reset;
      assign dout     = din;
    end else begin : g_regs
      logic [WIDTH-1:0] taps_r [DEPTH];

      // Shift chain; reset empties every stage so flushed pixels stay dark
      always_ff @(posedge clock_25) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) taps_r[i] <= {WIDTH{1'b0}};
        end else begin
          taps_r[0] <= din;
          for (int i = 1; i < DEPTH; i++) taps_r[i] <= taps_r[i-1];
        end
      end

      assign dout = taps_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/snake_hud_renderer.sv
// Per-pixel HUD classifier: play-field border, text labels via glyph ROM,
// and a frame-counted border flash while the game is over.
module snake_hud_renderer
  import snake_hud_renderer_pkg::*;
#(
  parameter int PIXEL_DISPLAY_BIT = DEF_PIXEL_DISPLAY_BIT,
  parameter int BORDER_X0         = DEF_BORDER_X0,
  parameter int BORDER_Y0         = DEF_BORDER_Y0,
  parameter int BORDER_W          = DEF_BORDER_W,
  parameter int BORDER_H          = DEF_BORDER_H,
  parameter int BORDER_T          = DEF_BORDER_T,
  parameter int TEXT_Y0           = DEF_TEXT_Y0,
  parameter int TEXT_H            = DEF_TEXT_H,
  parameter int N_LABELS          = 2,
  parameter logic [N_LABELS*(PIXEL_DISPLAY_BIT+1)-1:0] LABEL_X0 = {10'd362, 10'd108},
  parameter logic [N_LABELS*(PIXEL_DISPLAY_BIT+1)-1:0] LABEL_W  = {10'd81, 10'd63},
  parameter int ROM_X_W           = DEF_ROM_X_W,
  parameter logic [N_LABELS*ROM_X_W-1:0] LABEL_ROM_BASE = {8'd62, 8'd0},
  parameter int ROM_LATENCY       = DEF_ROM_LATENCY,
  parameter int FLASH_BIT         = DEF_FLASH_BIT
) (
  input  logic                       clock_25,
  input  logic                       reset,
  input  logic [PIXEL_DISPLAY_BIT:0] X,
  input  logic [PIXEL_DISPLAY_BIT:0] Y,
  input  logic                       game_over,
  input  logic                       rom_data,
  output logic [ROM_X_W-1:0]         rom_x,
  output logic [3:0]                 rom_y,
  output logic                       pixel_on,
  output logic [1:0]                 pixel_class
);

  localparam int PW = PIXEL_DISPLAY_BIT + 1;
  localparam int CW = FLASH_BIT + 1;
  localparam int BX1 = BORDER_X0 + BORDER_W - 1;
  localparam int BY1 = BORDER_Y0 + BORDER_H - 1;

  int                 x_s, y_s;
  logic               in_band_s, in_outer_s, in_inner_s, border_s, border_vis_s;
  logic               frame_start_s, text_hit_s;
  int                 label_lo_s [N_LABELS];
  int                 label_hi_s [N_LABELS];
  logic [N_LABELS-1:0] label_hit_s;
  logic [ROM_X_W-1:0] label_addr_s [N_LABELS];
  logic [ROM_X_W-1:0] rom_x_s;
  logic [3:0]         rom_y_s;

  flash_state_e       state_r, state_nx_s;
  logic [CW-1:0]      frame_cnt_r, frame_cnt_nx_s;

  logic [ROM_X_W-1:0] rom_x_r;
  logic [3:0]         rom_y_r;
  logic               border_q_r, text_q_r, border_d_s, text_d_s;
  pixel_class_e       class_s;
  logic [1:0]         pixel_class_r;
  logic               pixel_on_r;

  assign x_s = int'(X);
  assign y_s = int'(Y);

  // Stage 0 geometry: band, border ring and per-label hit/address
  always_comb begin
    in_band_s  = (y_s >= TEXT_Y0) && (y_s <= TEXT_Y0 + TEXT_H - 1);
    in_outer_s = (x_s >= BORDER_X0) && (x_s <= BX1) && (y_s >= BORDER_Y0) && (y_s <= BY1);
    in_inner_s = (x_s >= BORDER_X0 + BORDER_T) && (x_s <= BX1 - BORDER_T) &&
                 (y_s >= BORDER_Y0 + BORDER_T) && (y_s <= BY1 - BORDER_T);
    border_s   = in_outer_s && !in_inner_s && !in_band_s;
    rom_y_s    = in_band_s ? 4'(y_s - TEXT_Y0) : 4'd0;
    for (int i = 0; i < N_LABELS; i++) begin
      label_lo_s[i]   = int'(LABEL_X0[i*PW +: PW]);
      label_hi_s[i]   = label_lo_s[i] + int'(LABEL_W[i*PW +: PW]) - 1;
      label_hit_s[i]  = in_band_s && (x_s >= label_lo_s[i]) && (x_s <= label_hi_s[i]);
      label_addr_s[i] = ROM_X_W'(x_s - label_lo_s[i] +
                                 int'(LABEL_ROM_BASE[i*ROM_X_W +: ROM_X_W]));
    end
    // Walk downwards so the lowest-index label overrides on overlap
    text_hit_s = 1'b0;
    rom_x_s    = {ROM_X_W{1'b0}};
    for (int i = N_LABELS - 1; i >= 0; i--) begin
      rom_x_s    = label_hit_s[i] ? label_addr_s[i] : rom_x_s;
      text_hit_s = text_hit_s | label_hit_s[i];
    end
  end

  // Flash FSM next state; entering FLASH clears the counter even on a frame start
  always_comb begin
    state_nx_s     = state_r;
    frame_cnt_nx_s = frame_cnt_r;
    frame_start_s  = (X == {PW{1'b0}}) && (Y == {PW{1'b0}});
    case (state_r)
      ST_NORMAL: begin
        if (game_over) begin
          state_nx_s     = ST_FLASH;
          frame_cnt_nx_s = {CW{1'b0}};
        end else begin
          state_nx_s     = ST_NORMAL;
          frame_cnt_nx_s = frame_start_s ? frame_cnt_r + CW'(1'b1) : frame_cnt_r;
        end
      end
      ST_FLASH: begin
        state_nx_s     = game_over ? ST_FLASH : ST_NORMAL;
        frame_cnt_nx_s = frame_start_s ? frame_cnt_r + CW'(1'b1) : frame_cnt_r;
      end
      default: begin
        state_nx_s     = ST_NORMAL;
        frame_cnt_nx_s = {CW{1'b0}};
      end
    endcase
  end

  // Flash FSM state and frame counter registers
  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_r     <= ST_NORMAL;
      frame_cnt_r <= {CW{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      frame_cnt_r <= frame_cnt_nx_s;
    end
  end

  assign border_vis_s = (state_r == ST_NORMAL) ? 1'b1 : ~frame_cnt_r[FLASH_BIT];

  // Stage 1 registers: ROM address and flags (visibility folded in here)
  always_ff @(posedge clock_25) begin
    if (reset) begin
      rom_x_r    <= {ROM_X_W{1'b0}};
      rom_y_r    <= 4'd0;
      border_q_r <= 1'b0;
      text_q_r   <= 1'b0;
    end else begin
      rom_x_r    <= rom_x_s;
      rom_y_r    <= rom_y_s;
      border_q_r <= border_s && border_vis_s;
      text_q_r   <= text_hit_s;
    end
  end

  hud_delay_line #(
    .WIDTH (2),
    .DEPTH (ROM_LATENCY)
  ) u_flag_delay (
    .clock_25 (clock_25),
    .reset    (reset),
    .din      ({border_q_r, text_q_r}),
    .dout     ({border_d_s, text_d_s})
  );

  // Final classification: lit text beats border
  always_comb begin
    class_s = CLASS_NONE;
    if (text_d_s && rom_data) begin
      class_s = CLASS_TEXT;
    end else if (border_d_s) begin
      class_s = CLASS_BORDER;
    end else begin
      class_s = CLASS_NONE;
    end
  end

  // Output registers
  always_ff @(posedge clock_25) begin
    if (reset) begin
      pixel_class_r <= 2'd0;
      pixel_on_r    <= 1'b0;
    end else begin
      pixel_class_r <= class_s;
      pixel_on_r    <= (class_s != CLASS_NONE);
    end
  end

  assign rom_x       = rom_x_r;
  assign rom_y       = rom_y_r;
  assign pixel_class = pixel_class_r;
  assign pixel_on    = pixel_on_r;

endmodule

// File: tb/tb_snake_hud_renderer.sv
// Bench for snake_hud_renderer: two instances (ROM latency 1 and 3) fed by
// model ROMs, checked against a geometry/flash reference model.
module tb_snake_hud_renderer;

  logic       clock_25 = 1'b0;
  logic       reset = 1'b1;
  logic       game_over = 1'b0;
  logic [9:0] X = 10'd0, Y = 10'd0;
  logic       rom_data1, rom_data3;
  logic [7:0] rom_x1, rom_x3;
  logic [3:0] rom_y1, rom_y3;
  logic       on1, on3;
  logic [1:0] cls1, cls3;

  always #20 clock_25 = ~clock_25;

  snake_hud_renderer dut1 (
    .clock_25(clock_25), .reset(reset), .X(X), .Y(Y), .game_over(game_over),
    .rom_data(rom_data1), .rom_x(rom_x1), .rom_y(rom_y1),
    .pixel_on(on1), .pixel_class(cls1));

  snake_hud_renderer #(.ROM_LATENCY(3)) dut3 (
    .clock_25(clock_25), .reset(reset), .X(X), .Y(Y), .game_over(game_over),
    .rom_data(rom_data3), .rom_x(rom_x3), .rom_y(rom_y3),
    .pixel_on(on3), .pixel_class(cls3));

  // Glyph content: an arbitrary but irregular pattern; (0,0) is lit
  function automatic logic glyph(input int rx, input int ry);
    return ((rx * 3 + ry * 5 + 1) % 7) < 4;
  endfunction

  // Model ROMs: latency 1 and latency 3, addressed by each DUT
  logic [11:0] h1;
  logic [11:0] h3 [3];
  always @(posedge clock_25) begin
    h1    <= {rom_x1, rom_y1};
    h3[0] <= {rom_x3, rom_y3};
    h3[1] <= h3[0];
    h3[2] <= h3[1];
  end
  assign rom_data1 = glyph(int'(h1[11:4]), int'(h1[3:0]));
  assign rom_data3 = glyph(int'(h3[2][11:4]), int'(h3[2][3:0]));

  // Reference geometry from the published layout
  localparam int LX0 [2]  = '{108, 362};
  localparam int LW [2]   = '{63, 81};
  localparam int LBASE[2] = '{0, 62};

  function automatic bit m_band(input int y);
    return y >= 460 && y <= 475;
  endfunction

  function automatic int m_label(input int x, input int y);
    for (int i = 0; i < 2; i++)
      if (m_band(y) && x >= LX0[i] && x < LX0[i] + LW[i]) return i;
    return -1;
  endfunction

  function automatic int m_rom_x(input int x, input int y);
    int l = m_label(x, y);
    return (l < 0) ? 0 : (x - LX0[l] + LBASE[l]) % 256;
  endfunction

  function automatic int m_rom_y(input int y);
    return m_band(y) ? y - 460 : 0;
  endfunction

  function automatic bit m_border(input int x, input int y);
    bit outer = x >= 53 && x <= 680 && y >= 38 && y <= 450;
    bit inner = x >= 58 && x <= 675 && y >= 43 && y <= 445;
    return outer && !inner && !m_band(y);
  endfunction

  int compared = 0, mismatched = 0;
  int edge_n = 0;
  int exp_cls [8192];
  bit rst_at  [8192];
  bit m_flash = 1'b0;
  int m_cnt = 0;

  function automatic int exp_out(input int lat);
    int p = edge_n - lat - 1;
    if (p < 1) return 0;
    for (int e = p; e <= edge_n; e++) if (rst_at[e]) return 0;
    return exp_cls[p];
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // One pixel clock: drive, model, clock, compare
  task automatic cyc(input int x, input int y, input bit go, input bit rst);
    bit vis;
    int c, e1, e3;
    X = 10'(x); Y = 10'(y); game_over = go; reset = rst;
    vis = !m_flash || (((m_cnt >> 4) & 1) == 0);
    if (m_label(x, y) >= 0 && glyph(m_rom_x(x, y), m_rom_y(y))) c = 2;
    else if (m_border(x, y) && vis) c = 1;
    else c = 0;
    @(posedge clock_25);
    edge_n++;
    exp_cls[edge_n] = c;
    rst_at[edge_n]  = rst;
    if (rst) begin
      m_flash = 1'b0; m_cnt = 0;
    end else if (!m_flash && go) begin
      m_flash = 1'b1; m_cnt = 0;
    end else begin
      if (m_flash && !go) m_flash = 1'b0;
      if (x == 0 && y == 0) m_cnt = (m_cnt + 1) % 32;
    end
    #1;
    chk("rom_x_L1", int'(rom_x1), rst ? 0 : m_rom_x(x, y));
    chk("rom_y_L1", int'(rom_y1), rst ? 0 : m_rom_y(y));
    chk("rom_x_L3", int'(rom_x3), rst ? 0 : m_rom_x(x, y));
    chk("rom_y_L3", int'(rom_y3), rst ? 0 : m_rom_y(y));
    e1 = exp_out(1);
    e3 = exp_out(3);
    chk("class_L1", int'(cls1), e1);
    chk("on_L1", int'(on1), int'(e1 != 0));
    chk("class_L3", int'(cls3), e3);
    chk("on_L3", int'(on3), int'(e3 != 0));
  endtask

  initial begin
    int xs [14] = '{362, 442, 443, 53, 58, 680, 681, 107, 108, 170, 171, 109, 169, 0};
    int ys [14] = '{465, 465, 465, 38, 43, 450, 450, 460, 460, 470, 470, 475, 476, 1};
    int rx, ry;
    bit go, rst;

    // Reset held with a lit label pixel presented, then released
    for (int i = 0; i < 4; i++) cyc(108, 460, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(108, 460, 1'b0, 1'b0);

    // Address and border boundaries
    for (int i = 0; i < 14; i++) cyc(xs[i], ys[i], 1'b0, 1'b0);
    for (int x = 104; x <= 174; x++) cyc(x, 467, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(300, 300, 1'b0, 1'b0);

    // Game-over flash over 32 frames, then release
    for (int f = 0; f < 32; f++) begin
      cyc(0, 0, 1'b1, 1'b0);
      cyc(60, 40, 1'b1, 1'b0);
      cyc(300, 300, 1'b1, 1'b0);
    end
    cyc(60, 40, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(60, 40, 1'b0, 1'b0);

    // Into the dark half of the flash, then reset from FLASH
    for (int f = 0; f < 18; f++) begin
      cyc(0, 0, 1'b1, 1'b0);
      cyc(60, 40, 1'b1, 1'b0);
    end
    cyc(60, 40, 1'b1, 1'b1);
    cyc(60, 40, 1'b1, 1'b1);
    cyc(0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(60, 40, 1'b0, 1'b0);

    // Randomised pixels, frame starts, game_over toggles and occasional resets
    go = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: ry = 460 + $urandom_range(0, 15);
        1: ry = 36 + $urandom_range(0, 10);
        2: ry = 440 + $urandom_range(0, 40);
        default: ry = $urandom_range(0, 1023);
      endcase
      rx = $urandom_range(0, 799);
      if (i % 40 == 0) begin rx = 0; ry = 0; end
      if ($urandom_range(0, 299) == 0) go = !go;
      rst = ($urandom_range(0, 499) == 0);
      cyc(rx, ry, go, rst);
    end
    for (int i = 0; i < 6; i++) cyc(300, 300, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
